// File: rtl/tmr_counter_scrub.sv
// Triple-redundant counter: bitwise majority vote, word-level fault localisation, repair on every
// edge, persistent/uncorrectable fault detection. Optional injection ports under TMR_FAULT_INJ_EN.
module tmr_counter_scrub #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned SCRUB_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clr,
`ifdef TMR_FAULT_INJ_EN
    input  logic                 inj_valid,
    input  logic [1:0]           inj_sel,
    input  logic [WIDTH-1:0]     inj_mask,
`endif
    output logic [WIDTH-1:0]     q_out,
    output logic                 err_valid,
    output logic [2:0]           err_loc,
    output logic                 fail,
    output logic [3*CNT_W-1:0]   err_cnt
);

    localparam int unsigned STREAK_W = $clog2(SCRUB_MAX + 1);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StScrub = 2'b01,
        StFail  = 2'b10
    } state_t;

    logic [WIDTH-1:0]    r0, r1, r2;
    logic [WIDTH-1:0]    r0_next, r1_next, r2_next;
    logic [WIDTH-1:0]    voted;
    logic [WIDTH-1:0]    count_next;
    state_t              state, state_next;
    logic [STREAK_W-1:0] streak, streak_next, streak_inc;
    logic                fail_next;
    logic [3*CNT_W-1:0]  err_cnt_next;

    logic                e01, e12, e02;
    logic                all_eq, single, uncorr;
    logic [2:0]          single_loc;

    // Voting and classification
    assign voted      = (r0 & r1) | (r1 & r2) | (r0 & r2);
    assign q_out      = voted;
    assign count_next = voted + {{(WIDTH-1){1'b0}}, enable};

    assign e01 = (r0 == r1);
    assign e12 = (r1 == r2);
    assign e02 = (r0 == r2);

    // Equality is transitive, so the number of equal pairs is 0, 1 or 3.
    assign all_eq = e01 & e12;
    assign single = (e01 ^ e12 ^ e02) & ~all_eq;
    assign uncorr = ~e01 & ~e12 & ~e02;

    always_comb begin
        single_loc = 3'b000;
        if (single) begin
            if (e12) begin
                single_loc = 3'b001;
            end else if (e02) begin
                single_loc = 3'b010;
            end else begin
                single_loc = 3'b100;
            end
        end
    end

    assign err_valid = ~all_eq;
    assign err_loc   = uncorr ? 3'b111 : single_loc;

    // Replica reload: every replica takes the voted value, which repairs a single fault in one edge.
    always_comb begin
        r0_next = count_next;
        r1_next = count_next;
        r2_next = count_next;
`ifdef TMR_FAULT_INJ_EN
        if (inj_valid) begin
            unique case (inj_sel)
                2'd0:    r0_next = count_next ^ inj_mask;
                2'd1:    r1_next = count_next ^ inj_mask;
                2'd2:    r2_next = count_next ^ inj_mask;
                default: ;
            endcase
        end
`endif
    end

    // Per-replica saturating error counters; clr wins, uncorrectable events are not attributed.
    always_comb begin
        err_cnt_next = err_cnt;
        if (clr) begin
            err_cnt_next = '0;
        end else if (single) begin
            for (int i = 0; i < 3; i++) begin
                if (single_loc[i] && (err_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    err_cnt_next[i*CNT_W +: CNT_W] = err_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign streak_inc = streak + STREAK_W'(1);

    // Fault-tracking FSM; FAIL entry takes priority over clr.
    always_comb begin
        state_next  = state;
        streak_next = streak;
        fail_next   = fail;
        unique case (state)
            StRun: begin
                if (uncorr) begin
                    state_next = StFail;
                    fail_next  = 1'b1;
                end else if (clr) begin
                    streak_next = '0;
                end else if (single) begin
                    state_next  = StScrub;
                    streak_next = STREAK_W'(1);
                end
            end
            StScrub: begin
                if (uncorr) begin
                    state_next = StFail;
                    fail_next  = 1'b1;
                end else if (clr) begin
                    state_next  = StRun;
                    streak_next = '0;
                end else if (single) begin
                    streak_next = streak_inc;
                    if (streak_inc == STREAK_W'(SCRUB_MAX)) begin
                        state_next = StFail;
                        fail_next  = 1'b1;
                    end
                end else begin
                    state_next  = StRun;
                    streak_next = '0;
                end
            end
            StFail: begin
                fail_next = 1'b1;
                if (clr && !uncorr) begin
                    state_next  = StRun;
                    fail_next   = 1'b0;
                    streak_next = '0;
                end
            end
            default: begin
                // Corrupted state encoding is treated as a hard failure.
                state_next = StFail;
                fail_next  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0      <= '0;
            r1      <= '0;
            r2      <= '0;
            state   <= StRun;
            streak  <= '0;
            fail    <= 1'b0;
            err_cnt <= '0;
        end else begin
            r0      <= r0_next;
            r1      <= r1_next;
            r2      <= r2_next;
            state   <= state_next;
            streak  <= streak_next;
            fail    <= fail_next;
            err_cnt <= err_cnt_next;
        end
    end

    a_loc_consistent: assert property (@(posedge clk) disable iff (rst)
        err_valid == (err_loc != 3'b000));
    a_fail_matches_state: assert property (@(posedge clk) disable iff (rst)
        fail == (state == StFail));

endmodule

// File: doc/tmr_counter_scrub.md
Name: tmr_counter_scrub

Overview:
Synthesizable fault-tolerant counter: three replicated WIDTH-bit counters, a majority voter, word-level disagreement detection, faulty-replica localization and in-place repair.
It is the receiving end of replica fault injection: it detects, reports and repairs corruptions that the bench forces onto replicas.
It also flags persistent faults and uncorrectable faults (no two replicas agree).
Drop-in replacement for the plain TMR counter top; it adds status outputs.

Parameters:
WIDTH, 8, counter/replica width in bits
CNT_W, 4, width of each per-replica saturating error counter
SCRUB_MAX, 3, consecutive fault-detection cycles that declare a persistent fault (min 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  count enable; 1 = increment by 1 per cycle
clr  input  1  synchronous clear of fail flag, streak and error counters
q_out  output  WIDTH  voted counter value
err_valid  output  1  one-cycle pulse: replica disagreement seen this cycle
err_loc  output  3  one-hot faulty replica (bit i = replica i); 3'b111 = uncorrectable; 0 when err_valid=0
fail  output  1  sticky: uncorrectable or persistent fault
err_cnt  output  3*CNT_W  per-replica saturating counts; replica i at [i*CNT_W +: CNT_W]

Behaviour:
- Reset (async, rst=1): replicas r0..r2=0, state=RUN, streak=0, fail=0, err_cnt=0. Combinational outputs err_valid=0, err_loc=0 and q_out=0 follow from the reset registers.
- Registered state: r0,r1,r2 (WIDTH), state (RUN/SCRUB/FAIL), streak (clog2(SCRUB_MAX+1)), fail, err_cnt.
- voted = bitwise majority (r0&r1)|(r1&r2)|(r0&r2). q_out = voted, combinational from the replica registers, zero added latency.
- Word compare: e01=(r0==r1), e12=(r1==r2), e02=(r0==r2).
  - All equal: no fault.
  - Exactly one pair equal: single fault; the odd replica is faulty.
  - No pair equal: uncorrectable.
- err_valid / err_loc: combinational from the current replicas, valid in every state.
- Next value: every replica <= voted + enable, mod 2^WIDTH (0xFF+1 -> 0x00). All three replicas reload every cycle, so a single fault is repaired one edge after it appears. enable=0 holds voted and still repairs.
- err_cnt: on a single fault, increment the faulty replica's counter, saturating at 2^CNT_W-1. Uncorrectable faults do not increment. clr has priority and zeroes all counters that cycle.
- FSM, evaluated on each rising edge:
  - RUN: single fault -> SCRUB, streak=1. Uncorrectable -> FAIL. Otherwise stay.
  - SCRUB: no fault -> RUN, streak=0. Single fault -> streak+1; if streak+1==SCRUB_MAX -> FAIL. Uncorrectable -> FAIL.
  - FAIL: fail=1, counting continues on voted (best effort). clr=1 -> RUN, fail=0, streak=0.
  - fail is set on the edge that enters FAIL.
- Simultaneous events:
  - clr in RUN/SCRUB: forces RUN with streak=0, unless the same cycle is uncorrectable, which goes to FAIL. FAIL entry wins over clr.
  - clr with a single fault: the repair still happens, err_valid still pulses, and the counter stays 0.
- Mid-operation reset returns everything to reset values immediately, independent of clk.

Optional Feature:
TMR_FAULT_INJ_EN
- Defined: adds inputs inj_valid(1), inj_sel(2) and inj_mask(WIDTH). When inj_valid=1 and inj_sel<3, replica inj_sel loads (voted+enable)^inj_mask; the other replicas load normally. inj_sel=3 is ignored. The fault is visible the cycle after injection.
- Undefined: the ports do not exist and replicas always load voted+enable. Benches inject with hierarchical force on r0..r2.

Test Plan:
1. Reset, then enable=1 for 5 edges -> q_out 1,2,3,4,5; err_valid never 1; err_cnt=0; fail=0.
2. At q_out=5, force r1=0x0A for 1 cycle -> q_out continues 6,7; err_valid pulses once with err_loc=3'b010; err_cnt[1]=1; state RUN->SCRUB->RUN; all replicas equal after 1 edge.
3. Force r1=r2=0xEF for 1 cycle with enable=1 -> q_out=0xEF, then 0xF0; err_loc=3'b001 (r0 outvoted); err_cnt[0]=1; fail=0.
4. Force r0=0x14, r1=0x6F, r2=0xAF -> err_loc=3'b111; q_out=0x2F (bitwise majority); fail=1 next edge; err_cnt unchanged; clr=1 for 1 cycle -> fail=0, state RUN.
5. Corrupt r2 on 3 consecutive cycles (inj_sel=2, inj_mask=0x01) -> 3 consecutive err_loc=3'b100; fail=1 after the third detection; err_cnt[2]=3.
6. Count to 0xFF, enable=1 -> q_out=0x00 next edge. Then enable=0 and force r0=0x55 -> q_out held at 0x00, r0 repaired to 0x00 after 1 edge.
